sram_stream_ctrl: RTL and testbench

Valid/ready front end for one single-port synchronous SRAM (1-cycle read latency, write and read on `ce`). It sits directly upstream of the SRAM and arbitrates a write stream and a read-request stream onto the single port. Returning read data goes into a 2-entry response FIFO, so downstream backpressure never loses data. It sustains one access per cycle.

---
 rtl/sram_stream_ctrl.sv | 135 +++++++++++++
 tb/tb_sram_stream_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_stream_ctrl.sv
// Valid/ready front end arbitrating a write stream and a read-request stream onto one
// single-port SRAM, with a 2-entry response FIFO. Define SRAM_CTRL_RR_EN for round-robin arbitration.
module sram_stream_ctrl #(
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned WIDTH     = 512,
  parameter int unsigned ADDR_BITS = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 rd_req_valid,
  output logic                 rd_req_ready,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [WIDTH-1:0]     rd_data,
  output logic                 sram_ce,
  output logic                 sram_we,
  output logic [ADDR_BITS-1:0] sram_addr,
  output logic [WIDTH-1:0]     sram_din,
  input  logic [WIDTH-1:0]     sram_dout
);

  logic             inflight;
  logic [1:0]       count;
  logic [WIDTH-1:0] ent0;
  logic [WIDTH-1:0] ent1;
  logic             pop;
  logic             push;
  logic [2:0]       occ;
  logic             rd_ok;
  logic             rd_elig;
  logic             wr_gnt;
  logic             rd_gnt;

  assign rd_valid = (count != 2'd0);
  assign rd_data  = ent0;
  assign pop      = rd_valid & rd_ready;
  assign push     = inflight;

  // Credit counts the read already in flight; a same-cycle pop frees a slot immediately.
  assign occ     = 3'(count) + 3'(inflight) - 3'(pop);
  assign rd_ok   = (occ < 3'd2);
  assign rd_elig = rd_req_valid & rd_ok;

`ifdef SRAM_CTRL_RR_EN
  logic last_wr;

  // Round-robin: on contention the stream not granted last wins.
  always_comb begin
    wr_gnt = 1'b0;
    rd_gnt = 1'b0;
    if (!rst) begin
      wr_gnt = wr_valid & (~rd_elig | ~last_wr);
      rd_gnt = rd_elig  & (~wr_valid | last_wr);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_wr <= 1'b0;
    end else if (wr_gnt) begin
      last_wr <= 1'b1;
    end else if (rd_gnt) begin
      last_wr <= 1'b0;
    end
  end
`else
  // Fixed priority: writes always win.
  always_comb begin
    wr_gnt = 1'b0;
    rd_gnt = 1'b0;
    if (!rst) begin
      wr_gnt = wr_valid;
      rd_gnt = rd_elig & ~wr_valid;
    end
  end
`endif

  assign wr_ready     = wr_gnt;
  assign rd_req_ready = rd_gnt;

  // SRAM port drive; address and data are zeroed when idle.
  always_comb begin
    sram_ce   = 1'b0;
    sram_we   = 1'b0;
    sram_addr = '0;
    sram_din  = '0;
    if (wr_gnt) begin
      sram_ce   = 1'b1;
      sram_we   = 1'b1;
      sram_addr = wr_addr;
      sram_din  = wr_data;
    end else if (rd_gnt) begin
      sram_ce   = 1'b1;
      sram_addr = rd_addr;
    end
  end

  // In-flight tracking and response FIFO; ent0 is always the head.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= 1'b0;
      count    <= 2'd0;
      ent0     <= '0;
      ent1     <= '0;
    end else begin
      inflight <= rd_gnt;
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) ent0 <= sram_dout;
          else               ent1 <= sram_dout;
          count <= count + 2'd1;
        end
        2'b01: begin
          if (count == 2'd2) ent0 <= ent1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            ent0 <= sram_dout;
          end else begin
            ent0 <= ent1;
            ent1 <= sram_dout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_stream_ctrl.sv
// Directed testbench for sram_stream_ctrl with a behavioural 1-cycle-latency SRAM model.
// Honours SRAM_CTRL_RR_EN for the arbitration expectations.
module tb_sram_stream_ctrl;

  localparam int unsigned W  = 512;
  localparam int unsigned AB = 5;

  logic          clk;
  logic          rst;
  logic          wr_valid;
  logic          wr_ready;
  logic [AB-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic          rd_req_valid;
  logic          rd_req_ready;
  logic [AB-1:0] rd_addr;
  logic          rd_valid;
  logic          rd_ready;
  logic [W-1:0]  rd_data;
  logic          sram_ce;
  logic          sram_we;
  logic [AB-1:0] sram_addr;
  logic [W-1:0]  sram_din;
  logic [W-1:0]  sram_dout;

  logic [W-1:0]  mem [32];
  bit            preloaded = 1'b0;

  int n_pass  = 0;
  int n_total = 0;
  int n_wg;
  int n_rg;
  int exp_wg;
  int exp_rg;

  sram_stream_ctrl #(.DEPTH(32), .WIDTH(W), .ADDR_BITS(AB)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout(sram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model, preloaded with mem[i] = i on the first edge (reset is active then).
  always @(posedge clk) begin
    if (!preloaded) begin
      for (int i = 0; i < 32; i++) mem[i] <= W'(i);
      preloaded <= 1'b1;
    end else if (sram_ce) begin
      if (sram_we) mem[sram_addr] <= sram_din;
      else         sram_dout <= mem[sram_addr];
    end
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    rd_req_valid = 1'b0; rd_addr = '0; rd_ready = 1'b0;

    // Reset state, grants forced low while rst is high
    tick(); tick();
    wr_valid = 1'b1; rd_req_valid = 1'b1; #1;
    chk("rst_wr_ready", W'(wr_ready), W'(0));
    chk("rst_rd_req_ready", W'(rd_req_ready), W'(0));
    chk("rst_sram_ce", W'(sram_ce), W'(0));
    chk("rst_sram_we", W'(sram_we), W'(0));
    chk("rst_sram_addr", W'(sram_addr), W'(0));
    chk("rst_sram_din", sram_din, W'(0));
    chk("rst_rd_valid", W'(rd_valid), W'(0));
    chk("rst_rd_data", rd_data, W'(0));
    wr_valid = 1'b0; rd_req_valid = 1'b0;
    tick(); rst = 1'b0;

    // Stream of 8 reads, rd_ready held high
    rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      rd_req_valid = 1'b1; rd_addr = AB'(i); #1;
      chk("stream_grant", W'(rd_req_ready), W'(1));
      chk("stream_ce", W'(sram_ce), W'(1));
      if (i >= 2) begin
        chk("stream_rd_valid", W'(rd_valid), W'(1));
        chk("stream_rd_data", rd_data, W'(i - 2));
      end else begin
        chk("stream_rd_valid_early", W'(rd_valid), W'(0));
      end
    end
    tick(); rd_req_valid = 1'b0; #1;
    chk("stream_tail6", rd_data, W'(6));
    tick();
    chk("stream_tail7", rd_data, W'(7));
    chk("stream_tail7_valid", W'(rd_valid), W'(1));
    tick();
    chk("stream_drained", W'(rd_valid), W'(0));

    // Stall: rd_ready low, 5 reads of addr 10..14
    rd_ready = 1'b0;
    tick(); rd_req_valid = 1'b1; rd_addr = AB'(10); #1;
    chk("stall_g0", W'(rd_req_ready), W'(1));
    tick(); rd_addr = AB'(11); #1;
    chk("stall_g1", W'(rd_req_ready), W'(1));
    tick(); rd_addr = AB'(12); #1;
    chk("stall_block", W'(rd_req_ready), W'(0));
    chk("stall_ce", W'(sram_ce), W'(0));
    tick();
    chk("stall_block2", W'(rd_req_ready), W'(0));
    chk("stall_rd_valid", W'(rd_valid), W'(1));
    chk("stall_head", rd_data, W'(10));
    tick(); rd_ready = 1'b1; #1;
    chk("stall_release", W'(rd_req_ready), W'(1));
    chk("stall_pop10", rd_data, W'(10));
    tick(); rd_addr = AB'(13); #1;
    chk("stall_g3", W'(rd_req_ready), W'(1));
    chk("stall_pop11", rd_data, W'(11));
    tick(); rd_addr = AB'(14); #1;
    chk("stall_g4", W'(rd_req_ready), W'(1));
    chk("stall_pop12", rd_data, W'(12));
    tick(); rd_req_valid = 1'b0; #1;
    chk("stall_pop13", rd_data, W'(13));
    tick();
    chk("stall_pop14", rd_data, W'(14));
    tick();
    chk("stall_empty", W'(rd_valid), W'(0));

    // Write A5.. to addr 3, then read it back
    rd_ready = 1'b0;
    tick(); wr_valid = 1'b1; wr_addr = AB'(3); wr_data = {64{8'hA5}}; #1;
    chk("wr_grant", W'(wr_ready), W'(1));
    chk("wr_we", W'(sram_we), W'(1));
    chk("wr_addr", W'(sram_addr), W'(3));
    chk("wr_din", sram_din, {64{8'hA5}});
    tick(); wr_valid = 1'b0; rd_req_valid = 1'b1; rd_addr = AB'(3); #1;
    chk("a5_rd_grant", W'(rd_req_ready), W'(1));
    chk("a5_rd_we", W'(sram_we), W'(0));
    tick(); rd_req_valid = 1'b0; #1;
    chk("a5_not_yet", W'(rd_valid), W'(0));
    tick();
    chk("a5_valid", W'(rd_valid), W'(1));
    chk("a5_data", rd_data, {64{8'hA5}});
    rd_ready = 1'b1;
    tick();
    chk("a5_popped", W'(rd_valid), W'(0));

    // Contention for 6 cycles
`ifdef SRAM_CTRL_RR_EN
    exp_wg = 3; exp_rg = 3;
`else
    exp_wg = 6; exp_rg = 0;
`endif
    n_wg = 0; n_rg = 0;
    wr_addr = AB'(20); wr_data = {64{8'h77}}; rd_addr = AB'(21);
    for (int i = 0; i < 6; i++) begin
      tick(); wr_valid = 1'b1; rd_req_valid = 1'b1; #1;
      chk("arb_one_grant", W'(wr_ready ^ rd_req_ready), W'(1));
      n_wg += int'(wr_ready);
      n_rg += int'(rd_req_ready);
    end
    chk("arb_wr_grants", W'(n_wg), W'(exp_wg));
    chk("arb_rd_grants", W'(n_rg), W'(exp_rg));
    tick(); wr_valid = 1'b0; rd_req_valid = 1'b0;
    tick(); tick(); tick();
    chk("arb_drained", W'(rd_valid), W'(0));

    // Read-after-write to addr 5
    rd_ready = 1'b0;
    tick(); wr_valid = 1'b1; wr_addr = AB'(5); wr_data = {64{8'h3C}}; #1;
    chk("raw_wr", W'(wr_ready), W'(1));
    tick(); wr_valid = 1'b0; rd_req_valid = 1'b1; rd_addr = AB'(5); #1;
    chk("raw_rd", W'(rd_req_ready), W'(1));
    tick(); rd_req_valid = 1'b0;
    tick();
    chk("raw_valid", W'(rd_valid), W'(1));
    chk("raw_data", rd_data, {64{8'h3C}});
    rd_ready = 1'b1;
    tick();
    chk("raw_popped", W'(rd_valid), W'(0));

    // Reset with one entry queued and one read in flight
    rd_ready = 1'b0;
    tick(); rd_req_valid = 1'b1; rd_addr = AB'(7); #1;
    chk("mr_g0", W'(rd_req_ready), W'(1));
    tick(); rd_req_valid = 1'b0;
    tick(); rd_req_valid = 1'b1; rd_addr = AB'(8); #1;
    chk("mr_queued", rd_data, W'(7));
    chk("mr_g1", W'(rd_req_ready), W'(1));
    tick(); rst = 1'b1; wr_valid = 1'b1; #1;
    chk("mr_rst_rd_gnt", W'(rd_req_ready), W'(0));
    chk("mr_rst_wr_gnt", W'(wr_ready), W'(0));
    chk("mr_rst_ce", W'(sram_ce), W'(0));
    tick(); rst = 1'b0; wr_valid = 1'b0; rd_req_valid = 1'b0; #1;
    chk("mr_rd_valid", W'(rd_valid), W'(0));
    chk("mr_rd_data", rd_data, W'(0));
    chk("mr_ce", W'(sram_ce), W'(0));
    chk("mr_we", W'(sram_we), W'(0));
    chk("mr_addr", W'(sram_addr), W'(0));
    chk("mr_din", sram_din, W'(0));
    tick();
    chk("mr_no_ghost", W'(rd_valid), W'(0));
    tick();
    chk("mr_no_ghost2", W'(rd_valid), W'(0));
    chk("mr_data_zero", rd_data, W'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
